// File: rtl/cart_load_buffer.sv
// Byte staging FIFO between the HPS ioctl download and the cartridge SDRAM port.
// Optional CART_LOAD_CHECKSUM_EN adds a 16-bit additive checksum of drained bytes.
module cart_load_buffer #(
    parameter int DEPTH       = 8,
    parameter int WAIT_MARGIN = 2,
    parameter int HOLDOFF     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_isROM,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        mem_we,
    output logic [24:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic        mem_ready,
    output logic [24:0] rom_size,
    output logic        size_valid,
    output logic        load_done,
    output logic        overflow,
    output logic [15:0] checksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CW-1:0] FULL_LVL  = CW'(DEPTH);
    localparam logic [CW-1:0] WAIT_LVL  = CW'(DEPTH - WAIT_MARGIN);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_WAITRDY,
        S_SIZE
    } state_t;

    state_t        state;
    logic [32:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [32:0]   head;
    logic          rom_q;
    logic          rise;
    logic          fall;
    logic          wr_req;
    logic          push;
    logic          pop;
    logic          drop;
    logic [24:0]   max_addr;
    logic [24:0]   max_base;
    logic [24:0]   max_next;
    logic          dl_ended;
    logic [HW-1:0] hold_cnt;
    logic [24:0]   size_s;

    assign rise   = ioctl_isROM & ~rom_q;
    assign fall   = ~ioctl_isROM & rom_q;
    assign wr_req = ioctl_isROM & ioctl_wr;
    assign pop    = (state == S_IDLE) && (count != '0) && mem_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle
    assign push   = wr_req & ((count != FULL_LVL) | pop);
    assign drop   = wr_req & ~push;
    assign head   = fifo_mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (pop && !push) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        max_base = rise ? 25'd0 : max_addr;
        max_next = max_base;
        if (push && (ioctl_addr > max_base)) begin
            max_next = ioctl_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {ioctl_addr, ioctl_dout};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_q      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
            overflow   <= 1'b0;
            max_addr   <= '0;
        end else begin
            rom_q      <= ioctl_isROM;
            count      <= count_next;
            ioctl_wait <= (count_next >= WAIT_LVL) & ioctl_isROM;
            max_addr   <= max_next;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (rise) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            hold_cnt   <= '0;
            size_s     <= '0;
            rom_size   <= '0;
            size_valid <= 1'b0;
            load_done  <= 1'b0;
            dl_ended   <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            if (rise) begin
                size_valid <= 1'b0;
                dl_ended   <= 1'b0;
            end else if (fall) begin
                dl_ended <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        mem_we              <= 1'b1;
                        {mem_addr, mem_din} <= head;
                        hold_cnt            <= '0;
                        state <= (HOLDOFF == 0) ? S_WAITRDY : S_HOLD;
                    end else if (dl_ended && (count == '0) && !rise) begin
                        dl_ended <= 1'b0;
                        size_s   <= 25'd1;
                        state    <= S_SIZE;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state <= S_WAITRDY;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                S_WAITRDY: begin
                    if (mem_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_SIZE: begin
                    // Stop doubling at bit 24 so the size saturates at 16 MiB
                    if ((size_s <= max_addr) && !size_s[24]) begin
                        size_s <= size_s << 1;
                    end else begin
                        rom_size   <= size_s;
                        size_valid <= 1'b1;
                        load_done  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CART_LOAD_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (rise) begin
            sum_q <= '0;
        end else if (mem_we) begin
            sum_q <= sum_q + {8'h00, mem_din};
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_cart_load_buffer.sv
// Scoreboard bench for cart_load_buffer: drained writes are matched against
// the bytes the bench queued, plus size, throttle, overflow and reset checks.
module tb_cart_load_buffer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_isROM = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wait;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_ready = 1'b0;
    logic [24:0] rom_size;
    logic        size_valid;
    logic        load_done;
    logic        overflow;
    logic [15:0] checksum;

    cart_load_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .ioctl_isROM(ioctl_isROM),
        .ioctl_wr   (ioctl_wr),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .ioctl_wait (ioctl_wait),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_ready  (mem_ready),
        .rom_size   (rom_size),
        .size_valid (size_valid),
        .load_done  (load_done),
        .overflow   (overflow),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          nwe = 0;
    int          nld = 0;
    int          n0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [15:0] exp_cs;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && load_done) nld++;
        if (!reset && mem_we) begin
            nwe++;
            if (exp_q.size() == 0) begin
                chk("we_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("we_addr", 32'(mem_addr), 32'(mon_e[32:8]));
                chk("we_data", 32'(mem_din), 32'(mon_e[7:0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [24:0] a, input logic [7:0] d,
                        input bit honor, input bit acc);
        int k;
        k = 0;
        while (honor && ioctl_wait && k < 200) begin
            tick(1);
            k++;
        end
        if (k >= 200) chk("wait_timeout", 32'd1, 32'd0);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        if (acc) exp_q.push_back({a, d});
        tick(1);
        ioctl_wr = 1'b0;
        tick(1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 1000) begin
            tick(1);
            k++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        tick(4);
    endtask

    task automatic start_dl();
        ioctl_isROM = 1'b0;
        tick(2);
        ioctl_isROM = 1'b1;
        tick(1);
    endtask

    task automatic end_dl(input logic [24:0] exp_size, input string tag);
        int k;
        int l0;
        l0 = nld;
        ioctl_isROM = 1'b0;
        k = 0;
        while (!size_valid && k < 100) begin
            tick(1);
            k++;
        end
        chk({tag, "_valid"}, 32'(size_valid), 32'd1);
        chk({tag, "_size"}, 32'(rom_size), 32'(exp_size));
        tick(2);
        chk({tag, "_done_once"}, 32'(nld - l0), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

    initial begin
        tick(3);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_din", 32'(mem_din), 32'd0);
        chk("rst_size", 32'(rom_size), 32'd0);
        chk("rst_valid", 32'(size_valid), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cs", 32'(checksum), 32'd0);
        reset = 1'b0;
        tick(1);

        // Streaming download with the SDRAM always ready
        mem_ready = 1'b1;
        n0 = nwe;
        start_dl();
        for (int i = 0; i < 16; i++) push(25'(i), 8'(8'hA0 + i), 1'b1, 1'b1);
        drain();
        chk("stream_nwe", 32'(nwe - n0), 32'd16);
        chk("stream_ovf", 32'(overflow), 32'd0);
        end_dl(25'h10, "stream");

        // Stalled SDRAM: throttle threshold and drop on full
        mem_ready = 1'b0;
        n0 = nwe;
        start_dl();
        chk("valid_clr_rise", 32'(size_valid), 32'd0);
        for (int i = 0; i < 5; i++) push(25'(i), 8'(8'h50 + i), 1'b0, 1'b1);
        chk("wait_at5", 32'(ioctl_wait), 32'd0);
        push(25'd5, 8'h55, 1'b0, 1'b1);
        chk("wait_at6", 32'(ioctl_wait), 32'd1);
        push(25'd6, 8'h56, 1'b0, 1'b1);
        push(25'd7, 8'h57, 1'b0, 1'b1);
        chk("full_no_ovf", 32'(overflow), 32'd0);
        push(25'd8, 8'h58, 1'b0, 1'b0);
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("stall_nwe", 32'(nwe - n0), 32'd0);
        mem_ready = 1'b1;
        drain();
        chk("stall_nwe_after", 32'(nwe - n0), 32'd8);
        end_dl(25'h8, "dropmax");

        // Push and pop in the same cycle at full occupancy
        mem_ready = 1'b0;
        n0 = nwe;
        start_dl();
        chk("ovf_clr_rise", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) push(25'(8'h20 + i), 8'(8'h30 + i), 1'b0, 1'b1);
        mem_ready  = 1'b1;
        ioctl_addr = 25'h28;
        ioctl_dout = 8'h38;
        ioctl_wr   = 1'b1;
        exp_q.push_back({25'h28, 8'h38});
        tick(1);
        mem_ready = 1'b0;
        ioctl_wr  = 1'b0;
        tick(1);
        chk("pp_no_ovf", 32'(overflow), 32'd0);
        push(25'h29, 8'h39, 1'b0, 1'b0);
        chk("pp_still_full", 32'(overflow), 32'd1);
        mem_ready = 1'b1;
        drain();
        chk("pp_nwe", 32'(nwe - n0), 32'd9);
        end_dl(25'h40, "pp");

        // Size rounding boundaries
        start_dl();
        push(25'h4000, 8'h01, 1'b1, 1'b1);
        drain();
        end_dl(25'h8000, "sz4000");
        start_dl();
        push(25'h3FFF, 8'h02, 1'b1, 1'b1);
        drain();
        end_dl(25'h4000, "sz3fff");
        start_dl();
        push(25'h100, 8'h03, 1'b1, 1'b1);
        push(25'h010, 8'h04, 1'b1, 1'b1);
        drain();
        end_dl(25'h200, "szmax");
        start_dl();
        end_dl(25'h1, "szempty");
        start_dl();
        push(25'h1FFFFFF, 8'h05, 1'b1, 1'b1);
        drain();
        end_dl(25'h1000000, "szsat");

        // Reset while the FSM sits in HOLD
        mem_ready = 1'b0;
        n0 = nwe;
        start_dl();
        push(25'd0, 8'h11, 1'b0, 1'b1);
        push(25'd1, 8'h22, 1'b0, 1'b1);
        push(25'd2, 8'h33, 1'b0, 1'b1);
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        #2;
        reset = 1'b1;
        mem_ready = 1'b0;
        ioctl_isROM = 1'b0;
        #1;
        chk("rsthold_we", 32'(mem_we), 32'd0);
        chk("rsthold_valid", 32'(size_valid), 32'd0);
        exp_q.delete();
        tick(2);
        reset = 1'b0;
        mem_ready = 1'b1;
        tick(20);
        chk("rsthold_fifo_empty", 32'(nwe - n0), 32'd1);
        chk("rsthold_size", 32'(rom_size), 32'd0);
        chk("rsthold_wait", 32'(ioctl_wait), 32'd0);
        start_dl();
        for (int i = 0; i < 4; i++) push(25'(i), 8'(8'hC0 + i), 1'b1, 1'b1);
        drain();
        end_dl(25'h4, "postrst");

        // Checksum over FF, FF, 02
        start_dl();
        push(25'd0, 8'hFF, 1'b1, 1'b1);
        push(25'd1, 8'hFF, 1'b1, 1'b1);
        push(25'd2, 8'h02, 1'b1, 1'b1);
        drain();
        end_dl(25'h4, "cs");
`ifdef CART_LOAD_CHECKSUM_EN
        exp_cs = 16'h0200;
`else
        exp_cs = 16'h0000;
`endif
        chk("checksum", 32'(checksum), 32'(exp_cs));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
